// File: rtl/ahb_apb_bridge_param.sv
// AHB-to-APB bridge with parameterised slave decode and APB wait timeout.
// Optional feature macro: BRIDGE_ERR_RESP_EN. When it is defined, slave
// errors, timeouts and bad slave indices return a two-cycle AHB ERROR
// response. When it is undefined, they complete with OKAY.
//
// state  | meaning
// IDLE   | no transfer in flight, ready for an address phase
// WWAIT  | write data phase, capture hwdata
// SETUP  | APB setup: psel high, penable low
// ACCESS | APB access: psel and penable high, wait for pready or timeout
// DONE   | one-cycle OKAY completion, may sample the next transfer
// ERR1   | first ERROR cycle, hreadyout low
// ERR2   | second ERROR cycle, hreadyout high, may sample the next transfer
module ahb_apb_bridge_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic               hwrite,
  input  logic               hreadyin,
  input  logic [1:0]         htrans,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  output logic [DATA_W-1:0]  hrdata,
  output logic               hreadyout,
  output logic [1:0]         hresp,
  output logic [ADDR_W-1:0]  paddr,
  output logic [DATA_W-1:0]  pwdata,
  output logic               pwrite,
  output logic [NUM_SLV-1:0] psel,
  output logic               penable,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

`ifdef BRIDGE_ERR_RESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WWAIT, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [NUM_SLV-1:0]  sel_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W-1:0]   hrdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [ADDR_W-1:0]   slv_idx;
  logic                slv_bad;
  logic [NUM_SLV-1:0]  slv_onehot;
  logic                can_sample;
  logic                xfer;
  logic                timeout_hit;
  logic                slv_err;
  state_t              err_path;

  // Slave decode: every address bit above SEL_LSB forms the index, so any
  // nonzero bit above the select field is treated as an out-of-range slave.
  always_comb begin
    slv_idx    = haddr >> SEL_LSB;
    slv_bad    = (slv_idx >= ADDR_W'(NUM_SLV));
    slv_onehot = NUM_SLV'(1) << slv_idx[SEL_W-1:0];
  end

  assign can_sample  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign xfer        = can_sample && hreadyin && htrans[1];
  assign timeout_hit = (TIMEOUT != 0) && (state_q == S_ACCESS) && !pready && (cnt_q == '0);
  assign slv_err     = ERR_EN && pslverr;
  assign err_path    = ERR_EN ? S_ERR1 : S_DONE;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (xfer) begin
          if (slv_bad)     state_d = err_path;
          else if (hwrite) state_d = S_WWAIT;
          else             state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WWAIT:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready)           state_d = slv_err ? S_ERR1 : S_DONE;
        else if (timeout_hit) state_d = err_path;
      end
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register, address/data latches and the down-counting wait timer
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      sel_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        sel_q   <= slv_bad ? '0 : slv_onehot;
        if (slv_bad) hrdata_q <= '0;
      end
      if (state_q == S_WWAIT) pwdata_q <= hwdata;
      if (state_q == S_ACCESS) begin
        if (pready && !write_q) hrdata_q <= slv_err ? '0 : prdata;
        else if (timeout_hit)   hrdata_q <= '0;
      end
      if (state_q == S_SETUP)
        cnt_q <= CNT_LOAD;
      else if ((state_q == S_ACCESS) && (state_d == S_ACCESS) && (cnt_q != '0))
        cnt_q <= cnt_q - 1'b1;
      else if (state_q != S_ACCESS)
        cnt_q <= '0;
    end
  end

  // APB and AHB outputs decoded from state
  always_comb begin
    paddr     = addr_q;
    pwrite    = write_q;
    pwdata    = pwdata_q;
    hrdata    = hrdata_q;
    psel      = ((state_q == S_SETUP) || (state_q == S_ACCESS)) ? sel_q : '0;
    penable   = (state_q == S_ACCESS);
    hreadyout = !((state_q == S_WWAIT) || (state_q == S_SETUP) ||
                  (state_q == S_ACCESS) || (state_q == S_ERR1));
  end

`ifdef BRIDGE_ERR_RESP_EN
  // ERROR response covers both error cycles
  assign hresp = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
`else
  assign hresp = 2'b00;
`endif

endmodule
